rf_wb_arbiter: RTL and testbench

Write-back arbiter between the functional units and the register file's per-unit write ports. Accepts results from NUM_FU functional units over a valid/ready handshake and grants at most NUM_WP writes per cycle in round-robin order. Granted results are driven as registered write-port signals (enable, address, data) into the register file's write ports. Stalled units hold their result until granted.

---
 rtl/rf_wb_arbiter.sv | 91 +++++++++
 tb/tb_rf_wb_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: up to NUM_WP round-robin grants per cycle into registered
// register-file write ports; rd==0 results are accepted and dropped.
module rf_wb_arbiter #(
  parameter int NUM_FU = 10,
  parameter int NUM_WP = 2,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_FU-1:0]        fu_valid,
  input  logic [5*NUM_FU-1:0]      fu_rd,
  input  logic [DATA_W*NUM_FU-1:0] fu_data,
  output logic [NUM_FU-1:0]        fu_ready,
  output logic [NUM_WP-1:0]        wp_en,
  output logic [5*NUM_WP-1:0]      wp_addr,
  output logic [DATA_W*NUM_WP-1:0] wp_data,
  output logic                     busy
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  next_ptr;
  logic [NUM_WP-1:0] gnt_vld;
  logic [4:0]        gnt_rd   [NUM_WP];
  logic [DATA_W-1:0] gnt_data [NUM_WP];

  // Scan from ptr with wraparound; a nonzero rd already granted this cycle blocks
  // later requesters so no two ports ever write the same register.
  always_comb begin
    int   n;
    int   idx;
    logic clash;
    fu_ready = '0;
    gnt_vld  = '0;
    next_ptr = ptr;
    n        = 0;
    idx      = 0;
    clash    = 1'b0;
    for (int k = 0; k < NUM_WP; k++) begin
      gnt_rd[k]   = '0;
      gnt_data[k] = '0;
    end
    for (int j = 0; j < NUM_FU; j++) begin
      idx = int'(ptr) + j;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      for (int i = 0; i < NUM_FU; i++) begin
        if (i == idx && rst && fu_valid[i]) begin
          if (fu_rd[5*i +: 5] == 5'd0) begin
            fu_ready[i] = 1'b1;
          end else if (n < NUM_WP) begin
            clash = 1'b0;
            for (int k = 0; k < NUM_WP; k++)
              if (gnt_vld[k] && gnt_rd[k] == fu_rd[5*i +: 5]) clash = 1'b1;
            if (!clash) begin
              fu_ready[i] = 1'b1;
              for (int k = 0; k < NUM_WP; k++) begin
                if (k == n) begin
                  gnt_vld[k]  = 1'b1;
                  gnt_rd[k]   = fu_rd[5*i +: 5];
                  gnt_data[k] = fu_data[DATA_W*i +: DATA_W];
                end
              end
              n = n + 1;
              next_ptr = (i == NUM_FU-1) ? '0 : PTR_W'(i + 1);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr     <= '0;
      wp_en   <= '0;
      wp_addr <= '0;
      wp_data <= '0;
      busy    <= 1'b0;
    end else begin
      ptr  <= next_ptr;
      busy <= |(fu_valid & ~fu_ready);
      for (int k = 0; k < NUM_WP; k++) begin
        wp_en[k]                   <= gnt_vld[k];
        wp_addr[5*k +: 5]          <= gnt_vld[k] ? gnt_rd[k] : 5'd0;
        wp_data[DATA_W*k +: DATA_W] <= gnt_vld[k] ? gnt_data[k] : '0;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected writes go into a queue that a
// negedge monitor drains whenever any write port is enabled.
module tb_rf_wb_arbiter;

  localparam int NUM_FU = 10;
  localparam int NUM_WP = 2;
  localparam int DATA_W = 32;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_FU-1:0]        fu_valid;
  logic [5*NUM_FU-1:0]      fu_rd;
  logic [DATA_W*NUM_FU-1:0] fu_data;
  logic [NUM_FU-1:0]        fu_ready;
  logic [NUM_WP-1:0]        wp_en;
  logic [5*NUM_WP-1:0]      wp_addr;
  logic [DATA_W*NUM_WP-1:0] wp_data;
  logic                     busy;

  typedef struct packed {
    logic [1:0]  en;
    logic [9:0]  addr;
    logic [63:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  bit  mon_on   = 1'b0;

  rf_wb_arbiter #(.NUM_FU(NUM_FU), .NUM_WP(NUM_WP), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .fu_valid(fu_valid), .fu_rd(fu_rd), .fu_data(fu_data),
    .fu_ready(fu_ready), .wp_en(wp_en), .wp_addr(wp_addr), .wp_data(wp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on && wp_en !== 2'b00) begin
      wr_t act, exp;
      act = '{en: wp_en, addr: wp_addr, data: wp_data};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL wp_unexpected: got %0h, expected no write", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          n_errors++;
          $display("FAIL wp_write: got %0h, expected %0h", act, exp);
        end
      end
    end
  end

  task automatic set_unit(input int i, input logic [4:0] rd, input logic [31:0] d);
    fu_valid[i]          = 1'b1;
    fu_rd[5*i +: 5]      = rd;
    fu_data[32*i +: 32]  = d;
  endtask

  // Called at a negedge with inputs applied; units drop valid once accepted.
  task automatic cycle(input string name, input logic [9:0] exp_rdy, input logic [1:0] en,
                       input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1, input logic exp_busy);
    logic [9:0] rdy;
    #1;
    rdy = fu_ready;
    chk({name, "_ready"}, 128'(rdy), 128'(exp_rdy));
    if (en != 2'b00) exp_q.push_back('{en: en, addr: {a1, a0}, data: {d1, d0}});
    @(posedge clk);
    @(negedge clk);
    chk({name, "_busy"}, 128'(busy), 128'(exp_busy));
    fu_valid = fu_valid & ~rdy;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b0;
    fu_valid = '0;
    fu_rd    = '0;
    fu_data  = '0;
    for (int i = 0; i < NUM_FU; i++) set_unit(i, 5'(i + 1), 32'hA000_0000 + i);
    #1;
    chk("reset_ready0", 128'(fu_ready), 128'(0));
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("reset_ready", 128'(fu_ready), 128'(0));
      chk("reset_outs", 128'({wp_en, wp_addr, wp_data, busy}), 128'(0));
    end
    rst    = 1'b1;
    mon_on = 1'b1;

    cycle("rr1", 10'h003, 2'b11, 5'd1, 32'hA000_0000, 5'd2,  32'hA000_0001, 1'b1);
    cycle("rr2", 10'h00C, 2'b11, 5'd3, 32'hA000_0002, 5'd4,  32'hA000_0003, 1'b1);
    cycle("rr3", 10'h030, 2'b11, 5'd5, 32'hA000_0004, 5'd6,  32'hA000_0005, 1'b1);
    cycle("rr4", 10'h0C0, 2'b11, 5'd7, 32'hA000_0006, 5'd8,  32'hA000_0007, 1'b1);
    cycle("rr5", 10'h300, 2'b11, 5'd9, 32'hA000_0008, 5'd10, 32'hA000_0009, 1'b0);

    set_unit(0, 5'd5, 32'hDEAD_BEEF);
    cycle("single", 10'h001, 2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'h0, 1'b0);

    set_unit(0, 5'd11, 32'h11);
    set_unit(1, 5'd12, 32'h12);
    set_unit(2, 5'd13, 32'h13);
    cycle("ptr1_a", 10'h006, 2'b11, 5'd12, 32'h12, 5'd13, 32'h13, 1'b1);
    cycle("ptr1_b", 10'h001, 2'b01, 5'd11, 32'h11, 5'd0, 32'h0, 1'b0);

    for (int i = 0; i < 4; i++) set_unit(i, 5'(20 + i), 32'h200 + i);
    rst = 1'b0;
    #1;
    chk("midrst_ready", 128'(fu_ready), 128'(0));
    @(posedge clk);
    @(negedge clk);
    chk("midrst_outs", 128'({wp_en, wp_addr, wp_data, busy}), 128'(0));
    rst = 1'b1;
    cycle("midrst_a", 10'h003, 2'b11, 5'd20, 32'h200, 5'd21, 32'h201, 1'b1);
    cycle("midrst_b", 10'h00C, 2'b11, 5'd22, 32'h202, 5'd23, 32'h203, 1'b0);

    set_unit(3, 5'd0, 32'h1234);
    set_unit(1, 5'd3, 32'h3333);
    cycle("rd0", 10'h00A, 2'b01, 5'd3, 32'h3333, 5'd0, 32'h0, 1'b0);

    set_unit(1, 5'd14, 32'h14);
    set_unit(2, 5'd15, 32'h15);
    set_unit(9, 5'd9,  32'h99);
    cycle("ptr2_a", 10'h204, 2'b11, 5'd15, 32'h15, 5'd9, 32'h99, 1'b1);
    cycle("ptr2_b", 10'h002, 2'b01, 5'd14, 32'h14, 5'd0, 32'h0, 1'b0);
    set_unit(9, 5'd9, 32'h9999);
    cycle("wrap", 10'h200, 2'b01, 5'd9, 32'h9999, 5'd0, 32'h0, 1'b0);

    set_unit(6, 5'd7, 32'h6666);
    set_unit(8, 5'd7, 32'h8888);
    cycle("samerd_a", 10'h040, 2'b01, 5'd7, 32'h6666, 5'd0, 32'h0, 1'b1);
    cycle("samerd_b", 10'h100, 2'b01, 5'd7, 32'h8888, 5'd0, 32'h0, 1'b0);

    cycle("idle", 10'h000, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
    chk("queue_drained", 128'(exp_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
